// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage controller between the EX/MEM and MEM/WB latches. Issues one
//   cache read or write per memory instruction, freezes the pipeline until
//   dhit, captures load data, resolves branches/jumps into a PC redirect,
//   latches halt and counts memory stall cycles.
//
// Handshake: a request strobe (dmemREN/dmemWEN) is held, together with a
//   stable address and store data, until the cycle dhit is seen high; that
//   edge completes the access. mem_ready high means every upstream latch
//   advances on the coming edge; low means they all hold.
//
// Ports
//   CLK, nRST                 clock, asynchronous active-low reset
//   DRen_i, DWen_i            memory read/write request (read wins if both)
//   alu_out_i, rdat2_i        effective address, store data
//   rdat1_i, Jaddr_i, npc_i   jr target, jump target, PC+4
//   extout_i                  sign-extended branch offset (words)
//   Branch_i .. halt_i        control bits from the EX/MEM latch
//   dmemREN/WEN/addr/store    cache request side
//   dhit, dmemload            cache completion and read data
//   mem_ready                 pipeline advance enable
//   load_data_o/load_valid_o  captured load word for MEM/WB
//   redirect, redirect_pc     PC redirect, valid while mem_ready is high
//   halt_o                    sticky halt
//   stall_cnt_o               saturating stall-cycle count
//   o_fsm_state               current FSM state (debug)
module mem_access_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        DRen_i,
    input  logic        DWen_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] rdat2_i,
    input  logic [31:0] rdat1_i,
    input  logic [31:0] Jaddr_i,
    input  logic [31:0] npc_i,
    input  logic [31:0] extout_i,
    input  logic        Branch_i,
    input  logic        BNE_i,
    input  logic        zero_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        halt_i,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        mem_ready,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        halt_o,
    output logic [31:0] stall_cnt_o,
    output logic [1:0]  o_fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_mem_op;
    logic        w_issue;
    logic        w_ready;
    logic        w_taken;
    logic        r_is_read;
    logic [31:0] r_load_data;
    logic [31:0] r_stall_cnt;

    assign w_mem_op = DRen_i | DWen_i;

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    w_issue = 1'b1;
                    w_next  = dhit ? S_DONE : S_REQ;
                end else begin
                    w_ready = 1'b1;
                    // halt is only taken once no access is pending
                    if (halt_i) w_next = S_HALT;
                end
            end
            S_REQ: begin
                w_issue = 1'b1;
                if (dhit) w_next = S_DONE;
            end
            S_DONE: begin
                // release cycle: latch still shows the finished instruction,
                // so no new access is started here
                w_ready = 1'b1;
                w_next  = S_IDLE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_IDLE;
            r_is_read   <= 1'b0;
            r_load_data <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_issue && dhit) begin
                r_is_read <= DRen_i;
                if (DRen_i) r_load_data <= dmemload;
            end
            if (!w_ready && (r_state != S_HALT) && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    // Reset gates the strobes combinationally so they drop without a clock.
    assign dmemREN      = nRST & w_issue & DRen_i;
    assign dmemWEN      = nRST & w_issue & DWen_i & ~DRen_i;
    assign dmemaddr     = alu_out_i;
    assign dmemstore    = rdat2_i;
    assign mem_ready    = ~nRST | w_ready;
    assign load_data_o  = r_load_data;
    assign load_valid_o = nRST & (r_state == S_DONE) & r_is_read;
    assign halt_o       = nRST & (r_state == S_HALT);
    assign stall_cnt_o  = r_stall_cnt;
    assign o_fsm_state  = r_state;

    assign w_taken     = jr_i | jump_i | (Branch_i & (BNE_i ? ~zero_i : zero_i));
    assign redirect    = nRST & w_ready & (r_state != S_HALT) & w_taken;
    assign redirect_pc = jr_i   ? rdat1_i :
                         jump_i ? Jaddr_i :
                                  npc_i + {extout_i[29:0], 2'b00};

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        DRen_i, DWen_i;
    logic [31:0] alu_out_i, rdat2_i, rdat1_i, Jaddr_i, npc_i, extout_i;
    logic        Branch_i, BNE_i, zero_i, jump_i, jr_i, halt_i;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        mem_ready;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_o;
    logic [31:0] stall_cnt_o;
    logic [1:0]  o_fsm_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_stall;

    mem_access_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .DRen_i(DRen_i), .DWen_i(DWen_i),
        .alu_out_i(alu_out_i), .rdat2_i(rdat2_i), .rdat1_i(rdat1_i),
        .Jaddr_i(Jaddr_i), .npc_i(npc_i), .extout_i(extout_i),
        .Branch_i(Branch_i), .BNE_i(BNE_i), .zero_i(zero_i),
        .jump_i(jump_i), .jr_i(jr_i), .halt_i(halt_i),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload),
        .mem_ready(mem_ready),
        .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .halt_o(halt_o), .stall_cnt_o(stall_cnt_o),
        .o_fsm_state(o_fsm_state)
    );

    // clock
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the active edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        DRen_i = 0; DWen_i = 0; alu_out_i = 0; rdat2_i = 0; rdat1_i = 0;
        Jaddr_i = 0; npc_i = 0; extout_i = 0; Branch_i = 0; BNE_i = 0;
        zero_i = 0; jump_i = 0; jr_i = 0; halt_i = 0; dhit = 0; dmemload = 0;
    endtask

    // memory instruction completing on request cycle n
    task automatic do_mem(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] ld,
                          input int n, input bit hlt);
        logic [31:0] e;
        clear_inputs();
        DRen_i = rd; DWen_i = wr; alu_out_i = addr; rdat2_i = data; halt_i = hlt;
        if (rd) exp_q.push_back(ld);
        for (int k = 1; k <= n; k++) begin
            dhit     = (k == n);
            dmemload = (k == n) ? ld : $urandom;
            #2;
            chk("req_ready", mem_ready, 0);
            chk("req_ren", dmemREN, rd);
            chk("req_wen", dmemWEN, wr & ~rd);
            chk("req_addr", dmemaddr, addr);
            chk("req_store", dmemstore, data);
            chk("req_halt", halt_o, 0);
            chk("req_redirect", redirect, 0);
            tick();
            exp_stall++;
        end
        // dhit in the release cycle must be ignored
        dhit = 1'($urandom_range(0, 1));
        dmemload = $urandom;
        #2;
        chk("done_ready", mem_ready, 1);
        chk("done_ren", dmemREN, 0);
        chk("done_wen", dmemWEN, 0);
        chk("done_valid", load_valid_o, rd);
        chk("done_stall", stall_cnt_o, exp_stall);
        chk("done_halt", halt_o, 0);
        if (rd) begin
            e = exp_q.pop_front();
            chk("done_data", load_data_o, e);
        end
        tick();
    endtask

    // non-memory instruction: one cycle, redirect from the branch rules
    task automatic do_br(input bit br, input bit bne, input bit z, input bit j,
                         input bit jr, input logic [31:0] r1, input logic [31:0] ja,
                         input logic [31:0] npc, input logic [31:0] ext, input bit hlt);
        bit          taken;
        logic [31:0] tgt;
        clear_inputs();
        Branch_i = br; BNE_i = bne; zero_i = z; jump_i = j; jr_i = jr;
        rdat1_i = r1; Jaddr_i = ja; npc_i = npc; extout_i = ext; halt_i = hlt;
        dhit = 1'($urandom_range(0, 1));
        taken = jr || j || (br && (bne ? !z : z));
        if (jr)     tgt = r1;
        else if (j) tgt = ja;
        else        tgt = npc + ext * 32'd4;
        #2;
        chk("br_ready", mem_ready, 1);
        chk("br_redirect", redirect, taken);
        chk("br_pc", redirect_pc, tgt);
        chk("br_ren", dmemREN, 0);
        chk("br_wen", dmemWEN, 0);
        chk("br_stall", stall_cnt_o, exp_stall);
        tick();
    endtask

    initial begin
        bit rd, wr;
        clear_inputs();
        exp_stall = 0;

        // reset held with a pending read
        nRST = 0;
        DRen_i = 1; alu_out_i = 32'h0000_0100;
        repeat (2) @(posedge CLK);
        #3;
        chk("rst_ren", dmemREN, 0);
        chk("rst_ready", mem_ready, 1);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_data", load_data_o, 0);
        chk("rst_valid", load_valid_o, 0);
        chk("rst_halt", halt_o, 0);
        chk("rst_redirect", redirect, 0);

        // release: strobe appears in the same cycle; 3-cycle miss
        nRST = 1;
        #1;
        chk("rel_ren", dmemREN, 1);
        chk("rel_ready", mem_ready, 0);
        chk("rel_addr", dmemaddr, 32'h0000_0100);
        tick();
        #2;
        chk("miss2_ren", dmemREN, 1);
        chk("miss2_ready", mem_ready, 0);
        tick();
        dhit = 1; dmemload = 32'hDEAD_BEEF;
        #2;
        chk("miss3_ren", dmemREN, 1);
        chk("miss3_ready", mem_ready, 0);
        tick();
        dhit = 0;
        #2;
        chk("miss_done_ready", mem_ready, 1);
        chk("miss_done_valid", load_valid_o, 1);
        chk("miss_done_data", load_data_o, 32'hDEAD_BEEF);
        chk("miss_done_stall", stall_cnt_o, 3);
        chk("miss_done_ren", dmemREN, 0);
        exp_stall = 3;
        tick();

        // store, immediate hit
        do_mem(0, 1, 32'h0000_0080, 32'h1234_5678, 32'h0, 1, 0);
        do_br(0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h1, 0);

        // branches and jumps
        do_br(1, 1, 0, 0, 0, 0, 0, 32'h40, 32'hFFFF_FFFE, 0);
        do_br(1, 1, 1, 0, 0, 0, 0, 32'h40, 32'hFFFF_FFFE, 0);
        do_br(1, 0, 1, 0, 0, 0, 0, 32'h40, 32'h0000_0010, 0);
        do_br(0, 0, 0, 1, 1, 32'h200, 32'h300, 32'h40, 32'h5, 0);
        do_br(0, 0, 0, 1, 0, 32'h200, 32'h300, 32'h40, 32'h5, 0);

        // both strobes requested: read wins
        do_mem(1, 1, 32'h0000_0044, 32'hCAFE_0000, 32'h0BAD_F00D, 2, 0);

        // halt coinciding with a memory op waits for the access
        do_mem(1, 0, 32'h0000_0048, 32'h0, 32'h5555_AAAA, 2, 1);

        // reset in the middle of an access
        clear_inputs();
        DRen_i = 1; alu_out_i = 32'h0000_0200;
        #2;
        chk("mid_ren", dmemREN, 1);
        tick();
        #2;
        nRST = 0;
        #1;
        chk("mid_rst_ren", dmemREN, 0);
        chk("mid_rst_ready", mem_ready, 1);
        tick();
        clear_inputs();
        nRST = 1;
        exp_stall = 0;
        #2;
        chk("mid_rel_stall", stall_cnt_o, 0);
        chk("mid_rel_ready", mem_ready, 1);
        tick();

        // randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                rd = 1'($urandom_range(0, 1));
                wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
                do_mem(rd, wr, $urandom, $urandom, $urandom, $urandom_range(1, 4), 0);
            end else begin
                do_br(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      $urandom, 0);
            end
        end

        // halt from IDLE
        do_br(0, 0, 0, 0, 0, 0, 0, 32'h20, 32'h0, 1);
        clear_inputs();
        DRen_i = 1; DWen_i = 1; dhit = 1; jump_i = 1; Jaddr_i = 32'h400;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("halt_o", halt_o, 1);
            chk("halt_ready", mem_ready, 0);
            chk("halt_ren", dmemREN, 0);
            chk("halt_wen", dmemWEN, 0);
            chk("halt_redirect", redirect, 0);
            chk("halt_stall", stall_cnt_o, exp_stall);
            tick();
        end
        nRST = 0;
        #1;
        chk("halt_rst", halt_o, 0);
        tick();
        clear_inputs();
        nRST = 1;
        #2;
        chk("halt_exit_ready", mem_ready, 1);
        chk("halt_exit_halt", halt_o, 0);
        chk("halt_exit_stall", stall_cnt_o, 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
